div_clk_monitor: RTL and testbench

//  Downstream checker for the odd-ratio clock dividers. Samples a divided clock as data
//  in the system clock domain and measures its period and high time in clk cycles.

---
 rtl/div_clk_monitor.sv | 207 ++++++++++++++++++++
 tb/tb_div_clk_monitor.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_clk_monitor.sv
// Divided-clock monitor: samples clk_in in the clk domain, measures its period and
// high time, and reports lock, out-of-tolerance periods and stuck clocks.
module div_clk_monitor #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned EXP_PERIOD = 3,
  parameter int unsigned TOL        = 0,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_in,
  input  logic             en,
  input  logic             clr_err,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             err_period,
  output logic             err_stuck
);

  // Good-period counter only has to reach LOCK_CNT.
  localparam int unsigned GoodW = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);

  // Inclusive acceptance window for a measured period.
  localparam int unsigned PerLo = (EXP_PERIOD > TOL) ? EXP_PERIOD - TOL : 0;
  localparam int unsigned PerHi = EXP_PERIOD + TOL;

  localparam logic [CNT_W-1:0] CntMax     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);
  localparam logic [GoodW-1:0] LockVal    = GoodW'(LOCK_CNT);

  typedef enum logic [1:0] {
    StIdle,
    StAcq,
    StMeas,
    StLocked
  } state_e;

  // Synchroniser and edge-detect delay.
  logic s1_q, s2_q, s3_q;
  logic rise;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [GoodW-1:0] good_q, good_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             errp_q, errp_d;
  logic             errs_q, errs_d;

  logic [CNT_W-1:0] pcnt_inc;
  logic [CNT_W-1:0] hcnt_inc;
  logic             good;
  logic             timeout;
  logic             set_errp;
  logic             set_errs;

  assign rise = s2_q & ~s3_q;

  // Counters saturate at all-ones instead of wrapping.
  assign pcnt_inc = (pcnt_q == CntMax) ? pcnt_q : pcnt_q + CntOne;
  assign hcnt_inc = (s2_q && (hcnt_q != CntMax)) ? hcnt_q + CntOne : hcnt_q;

  assign good    = (32'(pcnt_q) >= PerLo) && (32'(pcnt_q) <= PerHi);
  assign timeout = (pcnt_q == TimeoutVal) && !rise;

  // Two-flop synchroniser plus delay flop for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= clk_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Next-state logic for FSM, counters, measurement registers and sticky flags.
  always_comb begin
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    hcnt_d   = hcnt_q;
    good_d   = good_q;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = 1'b0;
    set_errp = 1'b0;
    set_errs = 1'b0;

    unique case (state_q)
      StIdle: begin
        pcnt_d  = '0;
        hcnt_d  = '0;
        good_d  = '0;
        state_d = StAcq;
      end

      StAcq: begin
        if (rise) begin
          // First edge only aligns the counters; the period before it is partial.
          pcnt_d  = CntOne;
          hcnt_d  = CntOne;
          good_d  = '0;
          state_d = StMeas;
        end else if (timeout) begin
          // Clearing lets a still-stuck clock raise a fresh timeout later.
          pcnt_d   = '0;
          hcnt_d   = '0;
          set_errs = 1'b1;
        end else begin
          pcnt_d = pcnt_inc;
          hcnt_d = hcnt_inc;
        end
      end

      StMeas, StLocked: begin
        if (rise) begin
          period_d = pcnt_q;
          high_d   = hcnt_q;
          valid_d  = 1'b1;
          pcnt_d   = CntOne;
          hcnt_d   = CntOne;
          if (!good) begin
            good_d   = '0;
            state_d  = StMeas;
            set_errp = (state_q == StLocked);
          end else if (state_q == StMeas) begin
            good_d = good_q + GoodW'(1);
            if ((good_q + GoodW'(1)) == LockVal) begin
              state_d = StLocked;
            end
          end
        end else if (timeout) begin
          pcnt_d   = '0;
          hcnt_d   = '0;
          good_d   = '0;
          set_errs = 1'b1;
          state_d  = StAcq;
        end else begin
          pcnt_d = pcnt_inc;
          hcnt_d = hcnt_inc;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Disable overrides everything; results and sticky flags are kept.
    if (!en) begin
      state_d  = StIdle;
      pcnt_d   = '0;
      hcnt_d   = '0;
      good_d   = '0;
      period_d = period_q;
      high_d   = high_q;
      valid_d  = 1'b0;
      set_errp = 1'b0;
      set_errs = 1'b0;
    end

    // A new error in the same cycle as clr_err wins.
    errp_d = (errp_q & ~clr_err) | set_errp;
    errs_d = (errs_q & ~clr_err) | set_errs;
  end

  // State, counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      pcnt_q   <= '0;
      hcnt_q   <= '0;
      good_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      errp_q   <= 1'b0;
      errs_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      hcnt_q   <= hcnt_d;
      good_q   <= good_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      errp_q   <= errp_d;
      errs_q   <= errs_d;
    end
  end

  assign period     = period_q;
  assign high_time  = high_q;
  assign valid      = valid_q;
  assign locked     = (state_q == StLocked);
  assign err_period = errp_q;
  assign err_stuck  = errs_q;

endmodule

// File: tb/tb_div_clk_monitor.sv
// Bench for div_clk_monitor: two instances (TOL=0 and TOL=1) share stimulus and are
// compared every cycle against a reference model based on edge timestamps.
module tb_div_clk_monitor;

  localparam int ExpPeriod = 3;
  localparam int LockCnt   = 4;
  localparam int Timeout   = 16;
  localparam int CntSat    = 255;
  localparam int MaxEdges  = 16384;

  localparam int ModeOff  = 0;
  localparam int ModeAcq  = 1;
  localparam int ModeMeas = 2;
  localparam int ModeLock = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_in = 1'b0;
  logic       en = 1'b0;
  logic       clr_err = 1'b0;

  logic [7:0] period0, high0, period1, high1;
  logic       valid0, locked0, errp0, errs0;
  logic       valid1, locked1, errp1, errs1;

  always #5 clk = ~clk;

  div_clk_monitor #(
    .CNT_W     (8),
    .EXP_PERIOD(3),
    .TOL       (0),
    .LOCK_CNT  (4),
    .TIMEOUT   (16)
  ) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .clk_in    (clk_in),
    .en        (en),
    .clr_err   (clr_err),
    .period    (period0),
    .high_time (high0),
    .valid     (valid0),
    .locked    (locked0),
    .err_period(errp0),
    .err_stuck (errs0)
  );

  div_clk_monitor #(
    .CNT_W     (8),
    .EXP_PERIOD(3),
    .TOL       (1),
    .LOCK_CNT  (4),
    .TIMEOUT   (16)
  ) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .clk_in    (clk_in),
    .en        (en),
    .clr_err   (clr_err),
    .period    (period1),
    .high_time (high1),
    .valid     (valid1),
    .locked    (locked1),
    .err_period(errp1),
    .err_stuck (errs1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int valid_cnt0 = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference model: per-edge input history, period = distance between rising-edge
  // timestamps, high time = number of high samples inside that window.
  bit xh [MaxEdges];
  int e = 0;           // index of the next clk edge to be processed
  int reset_edge = 0;  // first edge whose clk_in sample survives reset
  int tol [2] = '{0, 1};
  int m_mode [2];
  int m_streak [2];
  int m_origin [2];    // edge from which the running measurement is counted
  int m_period [2];
  int m_high [2];
  bit m_valid [2];
  bit m_errp [2];
  bit m_errs [2];

  function automatic bit hx(input int j);
    if (j < 0 || j < reset_edge) return 1'b0;
    return xh[j];
  endfunction

  task automatic model_reset();
    reset_edge = e;
    for (int i = 0; i < 2; i++) begin
      m_mode[i]   = ModeOff;
      m_streak[i] = 0;
      m_origin[i] = e;
      m_period[i] = 0;
      m_high[i]   = 0;
      m_valid[i]  = 1'b0;
      m_errp[i]   = 1'b0;
      m_errs[i]   = 1'b0;
    end
  endtask

  task automatic model_edge(input bit x, input bit en_v, input bit clr_v, input bit rst_v);
    int ec;
    bit rise;
    ec = e;
    e++;
    xh[ec] = x;
    if (rst_v) begin
      model_reset();
      return;
    end
    // The sample taken two edges ago is what the edge detector sees now.
    rise = hx(ec - 2) && !hx(ec - 3);
    for (int i = 0; i < 2; i++) begin
      int pc;
      int hc;
      bit good;
      bit setp;
      bit sets;
      pc = ec - m_origin[i];
      if (pc > CntSat) pc = CntSat;
      hc = 0;
      for (int j = m_origin[i]; j < ec; j++) hc += int'(hx(j - 2));
      if (hc > CntSat) hc = CntSat;
      good = (pc >= ExpPeriod - tol[i]) && (pc <= ExpPeriod + tol[i]);
      setp = 1'b0;
      sets = 1'b0;
      m_valid[i] = 1'b0;
      if (!en_v) begin
        m_mode[i]   = ModeOff;
        m_origin[i] = ec + 1;
        m_streak[i] = 0;
      end else if (m_mode[i] == ModeOff) begin
        m_mode[i]   = ModeAcq;
        m_origin[i] = ec + 1;
      end else if (rise) begin
        m_origin[i] = ec;
        if (m_mode[i] == ModeAcq) begin
          m_mode[i]   = ModeMeas;
          m_streak[i] = 0;
        end else begin
          m_valid[i]  = 1'b1;
          m_period[i] = pc;
          m_high[i]   = hc;
          if (!good) begin
            setp        = (m_mode[i] == ModeLock);
            m_mode[i]   = ModeMeas;
            m_streak[i] = 0;
          end else if (m_mode[i] == ModeMeas) begin
            m_streak[i]++;
            if (m_streak[i] >= LockCnt) m_mode[i] = ModeLock;
          end
        end
      end else if (pc == Timeout) begin
        sets        = 1'b1;
        m_mode[i]   = ModeAcq;
        m_origin[i] = ec + 1;
      end
      m_errp[i] = (m_errp[i] && !clr_v) || setp;
      m_errs[i] = (m_errs[i] && !clr_v) || sets;
    end
  endtask

  task automatic check_outputs();
    check("u0.valid",      32'(valid0),  32'(m_valid[0]));
    check("u0.locked",     32'(locked0), 32'(m_mode[0] == ModeLock));
    check("u0.err_period", 32'(errp0),   32'(m_errp[0]));
    check("u0.err_stuck",  32'(errs0),   32'(m_errs[0]));
    check("u0.period",     32'(period0), 32'(m_period[0]));
    check("u0.high_time",  32'(high0),   32'(m_high[0]));
    check("u1.valid",      32'(valid1),  32'(m_valid[1]));
    check("u1.locked",     32'(locked1), 32'(m_mode[1] == ModeLock));
    check("u1.err_period", 32'(errp1),   32'(m_errp[1]));
    check("u1.err_stuck",  32'(errs1),   32'(m_errs[1]));
    check("u1.period",     32'(period1), 32'(m_period[1]));
    check("u1.high_time",  32'(high1),   32'(m_high[1]));
  endtask

  // One clk cycle: drive at negedge, model at posedge, compare at the next negedge.
  task automatic cyc(input bit x, input bit en_v, input bit clr_v);
    clk_in  = x;
    en      = en_v;
    clr_err = clr_v;
    @(posedge clk);
    model_edge(x, en_v, clr_v, rst);
    @(negedge clk);
    if (valid0) valid_cnt0++;
    check_outputs();
  endtask

  task automatic send_period(input int p, input int h);
    for (int k = 0; k < p; k++) cyc(k < h, 1'b1, 1'b0);
  endtask

  // Reset asserted between clock edges; outputs must clear without waiting for clk.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    check("rst.valid0",  32'(valid0),  32'd0);
    check("rst.locked0", 32'(locked0), 32'd0);
    check("rst.errp0",   32'(errp0),   32'd0);
    check("rst.errs0",   32'(errs0),   32'd0);
    check("rst.period0", 32'(period0), 32'd0);
    check("rst.high0",   32'(high0),   32'd0);
    check("rst.locked1", 32'(locked1), 32'd0);
    check("rst.period1", 32'(period1), 32'd0);
    model_reset();
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    bit hit;
    int v0;
    model_reset();
    @(negedge clk);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    // Nominal 1,1,0 pattern.
    repeat (8) send_period(3, 2);
    check("t1.locked",    32'(locked0), 32'd1);
    check("t1.period",    32'(period0), 32'd3);
    check("t1.high_time", 32'(high0),   32'd2);
    check("t1.errors",    32'({errp0, errs0}), 32'd0);

    // One long period while locked.
    send_period(4, 2);
    repeat (6) send_period(3, 2);
    check("t2.err_period", 32'(errp0),   32'd1);
    check("t2.relocked",   32'(locked0), 32'd1);
    check("t2.tol1_no_err", 32'(errp1),  32'd0);

    // Stuck low, then recover.
    repeat (20) cyc(1'b0, 1'b1, 1'b0);
    check("t3.err_stuck", 32'(errs0),   32'd1);
    check("t3.unlocked",  32'(locked0), 32'd0);
    repeat (8) send_period(3, 2);
    check("t3.relocked",  32'(locked0), 32'd1);

    // clr_err colliding with a fresh timeout, then clr_err alone.
    hit = 1'b0;
    for (int k = 0; k < 80 && !hit; k++) begin
      if (m_mode[0] == ModeAcq && m_errs[0] && (e - m_origin[0] == Timeout)) begin
        cyc(1'b0, 1'b1, 1'b1);
        check("t4.set_wins", 32'(errs0), 32'd1);
        hit = 1'b1;
      end else begin
        cyc(1'b0, 1'b1, 1'b0);
      end
    end
    check("t4.collision_reached", 32'(hit), 32'd1);
    cyc(1'b0, 1'b1, 1'b1);
    check("t4.clr_stuck",  32'(errs0), 32'd0);
    check("t4.clr_period", 32'(errp0), 32'd0);

    // Reset mid-period while locked; first valid on the second rise after release.
    repeat (8) send_period(3, 2);
    cyc(1'b1, 1'b1, 1'b0);
    async_reset();
    v0 = valid_cnt0;
    send_period(3, 2);
    send_period(3, 2);
    check("t5.first_valid", 32'(valid_cnt0 - v0), 32'd1);
    repeat (6) send_period(3, 2);
    check("t5.relocked", 32'(locked0), 32'd1);

    // Alternating 2/4 periods: in tolerance only for TOL=1.
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    repeat (6) begin
      send_period(2, 1);
      send_period(4, 2);
    end
    check("t6.locked_tol1", 32'(locked1), 32'd1);
    check("t6.no_err_tol1", 32'(errp1),   32'd0);
    repeat (4) cyc(1'b0, 1'b0, 1'b0);
    check("t6.unlock_en0", 32'(locked1), 32'd0);
    check("t6.period_hold", 32'(period1), 32'd2);
    check("t6.high_hold",   32'(high1),   32'd1);

    // Randomised mix of periods, long gaps, disables, clears and resets.
    for (int n = 0; n < 160; n++) begin
      int r;
      int p;
      int h;
      r = int'($urandom_range(0, 24));
      if (r == 0) begin
        repeat (int'($urandom_range(1, 4))) cyc(1'b0, 1'b0, ($urandom_range(0, 1) == 0));
      end else if (r == 1) begin
        async_reset();
      end else begin
        p = (r < 5) ? int'($urandom_range(15, 19)) : int'($urandom_range(2, 6));
        h = int'($urandom_range(1, p - 1));
        for (int k = 0; k < p; k++) cyc(k < h, 1'b1, ($urandom_range(0, 11) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
